key_array: RTL and testbench

//   Multi-channel key driver. KEY_NUM raw keys are handled by independent per-channel FSMs.

---
 rtl/key_array.sv | 181 ++++++++++++++++++
 tb/tb_key_array.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_array.sv
// Multi-channel key driver: per-channel synchroniser, press/release debounce,
// long-press detection and auto-repeat, all paced by one shared 1 ms tick.
module key_array #(
    parameter int unsigned SCLK_FREQ     = 50_000_000,
    parameter int unsigned KEY_NUM       = 4,
    parameter int unsigned PRESS_VOL     = 0,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 500,
    parameter int unsigned REPEAT_MS     = 100,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic               sclk,
    input  logic               nrst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_pulse,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_state
);
    localparam int unsigned DIV = SCLK_FREQ / 1000;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [31:0]   DB_LAST    = 32'(DEBOUNCE_MS - 1);
    localparam logic [31:0]   LONG_LAST  = 32'(LONG_PRESS_MS - 1);
    localparam logic [31:0]   REP_LAST   = 32'(REPEAT_MS - 1);
    localparam logic          PRESS_LVL  = (PRESS_VOL != 0);

    typedef enum logic [2:0] {
        IDLE, DB_PRESS, HELD, REPEAT, LONG, DB_REL
    } state_t;

    logic [PW-1:0]      pre_cnt_reg;
    logic               tick;
    logic [KEY_NUM-1:0] sync1_reg;
    logic [KEY_NUM-1:0] sync2_reg;
    logic [KEY_NUM-1:0] pressed;

    assign tick = (pre_cnt_reg == PRE_LAST);

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            pre_cnt_reg <= '0;
        end else if (tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    // Synchroniser resets to the released level so a held key looks like a fresh press.
    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            sync1_reg <= {KEY_NUM{~PRESS_LVL}};
            sync2_reg <= {KEY_NUM{~PRESS_LVL}};
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign pressed = ~(sync2_reg ^ {KEY_NUM{PRESS_LVL}});

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_ch
            state_t      state_reg, state_next;
            logic [31:0] cnt_reg, cnt_next;
            logic        pulse_reg, pulse_next;
            logic        long_reg, long_next;
            logic        rel_reg, rel_next;
            logic        st_reg, st_next;

            always_ff @(posedge sclk or negedge nrst) begin
                if (!nrst) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    pulse_reg <= 1'b0;
                    long_reg  <= 1'b0;
                    rel_reg   <= 1'b0;
                    st_reg    <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    pulse_reg <= pulse_next;
                    long_reg  <= long_next;
                    rel_reg   <= rel_next;
                    st_reg    <= st_next;
                end
            end

            // Level changes are checked before tick counting in every state.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                pulse_next = 1'b0;
                long_next  = 1'b0;
                rel_next   = 1'b0;
                st_next    = st_reg;
                case (state_reg)
                    IDLE: begin
                        if (pressed[gi]) begin
                            state_next = DB_PRESS;
                            cnt_next   = '0;
                        end
                    end
                    DB_PRESS: begin
                        if (!pressed[gi]) begin
                            state_next = IDLE;
                        end else if (tick) begin
                            if (cnt_reg == DB_LAST) begin
                                state_next = HELD;
                                cnt_next   = '0;
                                pulse_next = 1'b1;
                                st_next    = 1'b1;
                            end else begin
                                cnt_next = cnt_reg + 32'd1;
                            end
                        end
                    end
                    HELD: begin
                        if (!pressed[gi]) begin
                            state_next = DB_REL;
                            cnt_next   = '0;
                        end else if (tick) begin
                            if (cnt_reg == LONG_LAST) begin
                                state_next = (REPEAT_EN != 0) ? REPEAT : LONG;
                                cnt_next   = '0;
                                long_next  = 1'b1;
                            end else begin
                                cnt_next = cnt_reg + 32'd1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!pressed[gi]) begin
                            state_next = DB_REL;
                            cnt_next   = '0;
                        end else if (tick) begin
                            if (cnt_reg == REP_LAST) begin
                                cnt_next   = '0;
                                pulse_next = 1'b1;
                            end else begin
                                cnt_next = cnt_reg + 32'd1;
                            end
                        end
                    end
                    LONG: begin
                        if (!pressed[gi]) begin
                            state_next = DB_REL;
                            cnt_next   = '0;
                        end
                    end
                    DB_REL: begin
                        if (pressed[gi]) begin
                            state_next = HELD;
                            cnt_next   = '0;
                        end else if (tick) begin
                            if (cnt_reg == DB_LAST) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                                rel_next   = 1'b1;
                                st_next    = 1'b0;
                            end else begin
                                cnt_next = cnt_reg + 32'd1;
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign key_pulse[gi]   = pulse_reg;
            assign key_long[gi]    = long_reg;
            assign key_release[gi] = rel_reg;
            assign key_state[gi]   = st_reg;
        end
    endgenerate
endmodule

// File: tb/tb_key_array.sv
// Scoreboard bench for key_array: two instances (auto-repeat on / off) with
// 1 ms = 10 cycles; expected events carry an exact cycle derived from tick phase.
module tb_key_array;
    logic       sclk = 1'b0;
    logic       nrst;
    logic [3:0] key_a, key_b;
    logic [3:0] pulse_a, long_a, rel_a, state_a;
    logic [3:0] pulse_b, long_b, rel_b, state_b;

    key_array #(.SCLK_FREQ(10_000), .KEY_NUM(4), .REPEAT_EN(1)) dut_a (
        .sclk(sclk), .nrst(nrst), .key_in(key_a),
        .key_pulse(pulse_a), .key_long(long_a),
        .key_release(rel_a), .key_state(state_a)
    );

    key_array #(.SCLK_FREQ(10_000), .KEY_NUM(4), .REPEAT_EN(0)) dut_b (
        .sclk(sclk), .nrst(nrst), .key_in(key_b),
        .key_pulse(pulse_b), .key_long(long_b),
        .key_release(rel_b), .key_state(state_b)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rst_cyc = 0;

    typedef struct {
        int         kind;
        logic [3:0] mask;
        int         at;
    } evt_t;

    evt_t q_a[$];
    evt_t q_b[$];

    function automatic string kname(int k);
        if (k == 0) return "pulse";
        if (k == 1) return "long";
        return "release";
    endfunction

    // First tick edge at or after e; ticks land every 10 edges from reset release.
    function automatic int next_tick(int e);
        int t = e;
        while (t <= rst_cyc || ((t - rst_cyc) % 10) != 0) t++;
        return t;
    endfunction

    // Key changes right after edge t0: 2 sync stages, FSM moves at t0+3, 20 ticks follow.
    function automatic int db_done(int t0);
        return next_tick(t0 + 4) + 190;
    endfunction

    task automatic expect_evt(int dut, int kind, logic [3:0] mask, int at);
        evt_t e;
        e.kind = kind;
        e.mask = mask;
        e.at   = at;
        if (dut == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic observe(int dut, int kind, logic [3:0] mask);
        evt_t e;
        int   empty;
        empty = (dut == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        checks++;
        if (empty != 0) begin
            errors++;
            $display("FAIL unexpected dut%0d: got %s mask %b at cycle %0d, want no event",
                     dut, kname(kind), mask, cyc);
        end else begin
            if (dut == 0) e = q_a.pop_front();
            else          e = q_b.pop_front();
            if (e.kind != kind || e.mask !== mask || cyc < e.at - 2 || cyc > e.at + 2) begin
                errors++;
                $display("FAIL event dut%0d: got %s mask %b at cycle %0d, want %s mask %b at cycle %0d",
                         dut, kname(kind), mask, cyc, kname(e.kind), e.mask, e.at);
            end else begin
                $display("ok dut%0d %s mask %b at cycle %0d (expected %0d)",
                         dut, kname(kind), mask, cyc, e.at);
            end
        end
    endtask

    always @(negedge sclk) begin
        if (nrst === 1'b1) begin
            if (pulse_a != 4'b0) observe(0, 0, pulse_a);
            if (long_a  != 4'b0) observe(0, 1, long_a);
            if (rel_a   != 4'b0) observe(0, 2, rel_a);
            if (pulse_b != 4'b0) observe(1, 0, pulse_b);
            if (long_b  != 4'b0) observe(1, 1, long_b);
            if (rel_b   != 4'b0) observe(1, 2, rel_b);
        end
    end

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end else begin
            $display("ok %s = %b", name, act);
        end
    endtask

    task automatic edge1();
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_cycles(int n);
        repeat (n) @(posedge sclk);
    endtask

    task automatic drain(string name, int limit);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < limit) begin
            @(posedge sclk);
            n++;
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d events still pending, want 0",
                     name, q_a.size() + q_b.size());
        end else begin
            $display("ok drain_%s at cycle %0d", name, cyc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, p;
        nrst  = 1'b0;
        key_a = 4'b0000;
        key_b = 4'b0000;
        wait_cycles(5);
        #1;
        chk("reset_pulse_a", pulse_a, 4'b0000);
        chk("reset_long_a",  long_a,  4'b0000);
        chk("reset_rel_a",   rel_a,   4'b0000);
        chk("reset_state_a", state_a, 4'b0000);
        chk("reset_state_b", state_b, 4'b0000);

        // Reset release with ch0 still held
        key_a = 4'b1110;
        key_b = 4'b1111;
        edge1();
        nrst = 1'b1;
        rst_cyc = cyc;
        t0 = cyc;
        expect_evt(0, 0, 4'b0001, db_done(t0));
        wait_cycles(300);
        #1;
        key_a = 4'b1111;
        t1 = cyc;
        expect_evt(0, 2, 4'b0001, db_done(t1));
        drain("reset_press", 400);

        // 5 ms glitch: nothing may appear
        edge1();
        key_a = 4'b1110;
        wait_cycles(50);
        #1;
        key_a = 4'b1111;
        wait_cycles(300);
        #1;
        chk("glitch_state", state_a, 4'b0000);

        // Release bounce inside a hold
        edge1();
        key_a = 4'b1110;
        t0 = cyc;
        expect_evt(0, 0, 4'b0001, db_done(t0));
        wait_cycles(1000);
        #1;
        key_a = 4'b1111;
        wait_cycles(50);
        #1;
        key_a = 4'b1110;
        wait_cycles(1000);
        #1;
        chk("bounce_state", state_a, 4'b0001);
        key_a = 4'b1111;
        t1 = cyc;
        expect_evt(0, 2, 4'b0001, db_done(t1));
        drain("bounce", 400);

        // Short press on ch1
        edge1();
        key_a = 4'b1101;
        t0 = cyc;
        expect_evt(0, 0, 4'b0010, db_done(t0));
        wait_cycles(600);
        #1;
        chk("short_state_hi", state_a, 4'b0010);
        wait_cycles(400);
        #1;
        key_a = 4'b1111;
        t1 = cyc;
        expect_evt(0, 2, 4'b0010, db_done(t1));
        drain("short", 400);
        #1;
        chk("short_state_lo", state_a, 4'b0000);

        // Long press on ch2, repeat on (dut0) and off (dut1)
        edge1();
        key_a = 4'b1011;
        key_b = 4'b1011;
        t0 = cyc;
        p = db_done(t0);
        expect_evt(0, 0, 4'b0100, p);
        expect_evt(0, 1, 4'b0100, p + 5000);
        expect_evt(0, 0, 4'b0100, p + 6000);
        expect_evt(0, 0, 4'b0100, p + 7000);
        expect_evt(1, 0, 4'b0100, p);
        expect_evt(1, 1, 4'b0100, p + 5000);
        wait_cycles(5500);
        #1;
        chk("long_state_a", state_a, 4'b0100);
        chk("long_state_b", state_b, 4'b0100);
        wait_cycles(2500);
        #1;
        key_a = 4'b1111;
        key_b = 4'b1111;
        t1 = cyc;
        expect_evt(0, 2, 4'b0100, db_done(t1));
        expect_evt(1, 2, 4'b0100, db_done(t1));
        drain("long", 600);

        // All channels together, then reset in the middle of REPEAT
        edge1();
        key_a = 4'b0000;
        t0 = cyc;
        p = db_done(t0);
        expect_evt(0, 0, 4'b1111, p);
        expect_evt(0, 1, 4'b1111, p + 5000);
        wait_cycles(p + 5500 - cyc);
        #1;
        chk("concurrent_state", state_a, 4'b1111);
        drain("pre_reset", 10);
        #2;
        nrst = 1'b0;
        #1;
        chk("midrst_pulse", pulse_a, 4'b0000);
        chk("midrst_state", state_a, 4'b0000);
        edge1();
        nrst = 1'b1;
        rst_cyc = cyc;
        t0 = cyc;
        expect_evt(0, 0, 4'b1111, db_done(t0));
        wait_cycles(300);
        #1;
        key_a = 4'b1111;
        t1 = cyc;
        expect_evt(0, 2, 4'b1111, db_done(t1));
        drain("post_reset", 400);
        wait_cycles(100);
        #1;
        chk("final_state_a", state_a, 4'b0000);
        chk("final_state_b", state_b, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
